// File: rtl/stim_pulse_gen.sv
// stim_pulse_gen
//   Converts the controller's stimulation request into a charge-balanced
//   biphasic pulse train for the stimulator front-end. Each train is followed
//   by a refractory lockout. Requests that rise while the block is busy are
//   dropped and counted.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   enable       0 blocks new trains and stops a running one like abort
//   stim_req     stimulation request (level)
//   abort        stop the train once the current biphasic pulse completes
//   stim_ack     1-cycle strobe, request accepted
//   phase_pos    anodic phase drive
//   phase_neg    cathodic phase drive
//   busy         high in every state except IDLE
//   pulse_idx    index of the current pulse within the train
//   train_done   1-cycle strobe in the last NEG cycle of a completed train
//   dropped_cnt  saturating count of request rising edges seen while busy
module stim_pulse_gen #(
    parameter int PHASE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int PERIOD_CYCLES  = 20,
    parameter int NUM_PULSES     = 3,
    parameter int REFRACT_CYCLES = 50,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       stim_req,
    input  logic       abort,
    output logic       stim_ack,
    output logic       phase_pos,
    output logic       phase_neg,
    output logic       busy,
    output logic [7:0] pulse_idx,
    output logic       train_done,
    output logic [7:0] dropped_cnt
);

    localparam int INTER_CYCLES = PERIOD_CYCLES - 2*PHASE_CYCLES - GAP_CYCLES;
    localparam int MAX_A   = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
    localparam int MAX_B   = (INTER_CYCLES > REFRACT_CYCLES) ? INTER_CYCLES : REFRACT_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;

    if (PHASE_CYCLES < 1 || GAP_CYCLES < 0 || INTER_CYCLES < 1 ||
        NUM_PULSES < 1 || NUM_PULSES > 256 || REFRACT_CYCLES < 1 ||
        longint'(MAX_CNT) > (longint'(1) << CNT_W)) begin : g_bad_params
        $error("stim_pulse_gen: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_POS, S_GAP, S_NEG, S_INTER, S_REFRACT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             req_q;

    logic stop;
    logic last;
    logic last_pulse;

    assign stop       = abort || !enable;
    assign last       = (cnt_q == '0);
    assign last_pulse = (idx_q == 8'(NUM_PULSES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // cnt holds remaining cycles minus one in the current state; every
    // transition reloads it, so it never decrements past zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = last ? cnt_q : cnt_q - CNT_W'(1);
        idx_d      = idx_q;
        pend_d     = pend_q;
        stim_ack   = 1'b0;
        train_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                cnt_d  = '0;
                // The acknowledge is the only output decoded from the request
                // itself, so it lands in the cycle the request is taken.
                if (stim_req && enable && !abort && !rst) begin
                    stim_ack = 1'b1;
                    state_d  = S_POS;
                    cnt_d    = CNT_W'(PHASE_CYCLES - 1);
                    idx_d    = '0;
                end
            end
            S_POS: begin
                if (stop) pend_d = 1'b1;
                if (last) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_NEG;
                        cnt_d   = CNT_W'(PHASE_CYCLES - 1);
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    end
                end
            end
            S_GAP: begin
                if (stop) pend_d = 1'b1;
                if (last) begin
                    state_d = S_NEG;
                    cnt_d   = CNT_W'(PHASE_CYCLES - 1);
                end
            end
            S_NEG: begin
                if (stop) pend_d = 1'b1;
                // train_done depends only on the latched stop, never on the
                // live abort/enable inputs.
                if (last && last_pulse && !pend_q) train_done = 1'b1;
                if (last) begin
                    if (last_pulse || pend_q || stop) begin
                        state_d = S_REFRACT;
                        cnt_d   = CNT_W'(REFRACT_CYCLES - 1);
                    end else begin
                        state_d = S_INTER;
                        cnt_d   = CNT_W'(INTER_CYCLES - 1);
                    end
                end
            end
            S_INTER: begin
                // Between pulses there is no charge to balance: stop at once.
                if (stop) begin
                    state_d = S_REFRACT;
                    cnt_d   = CNT_W'(REFRACT_CYCLES - 1);
                end else if (last) begin
                    state_d = S_POS;
                    cnt_d   = CNT_W'(PHASE_CYCLES - 1);
                    idx_d   = idx_q + 8'd1;
                end
            end
            S_REFRACT: begin
                pend_d = 1'b0;
                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign phase_pos = (state_q == S_POS);
    assign phase_neg = (state_q == S_NEG);
    assign busy      = (state_q != S_IDLE);
    assign pulse_idx = idx_q;

    // A request level held across a train has no rising edge, so it is not
    // counted; it is simply re-accepted once the block is back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            req_q <= stim_req;
            if (busy && stim_req && !req_q && dropped_cnt != 8'hFF)
                dropped_cnt <= dropped_cnt + 8'd1;
        end
    end

    a_no_overlap: assert property (@(posedge clk) !(phase_pos && phase_neg));

endmodule

// File: tb/tb_stim_pulse_gen.sv
// tb_stim_pulse_gen
//   Directed timeline cases plus randomized traffic, all checked every cycle
//   against a timeline model: a train accepted at cycle a has pulse k's
//   positive phase starting at a+1+k*PERIOD, and a stop only moves the start
//   of the refractory window earlier. A second instance built with no
//   interphase gap is checked for its phase timing and for overlap.
module tb_stim_pulse_gen;

    localparam int P   = 4;
    localparam int G   = 2;
    localparam int PER = 20;
    localparam int N   = 3;
    localparam int R   = 50;

    logic       clk = 1'b0;
    logic       rst, enable, stim_req, abort;
    logic       stim_ack, phase_pos, phase_neg, busy, train_done;
    logic [7:0] pulse_idx, dropped_cnt;

    logic       g_req;
    logic       g_ack, g_pos, g_neg, g_busy, g_done;
    logic [7:0] g_idx, g_drop;

    always #5 clk = ~clk;

    stim_pulse_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .stim_req(stim_req), .abort(abort),
        .stim_ack(stim_ack), .phase_pos(phase_pos), .phase_neg(phase_neg),
        .busy(busy), .pulse_idx(pulse_idx), .train_done(train_done),
        .dropped_cnt(dropped_cnt)
    );

    stim_pulse_gen #(.GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst), .enable(1'b1), .stim_req(g_req), .abort(1'b0),
        .stim_ack(g_ack), .phase_pos(g_pos), .phase_neg(g_neg),
        .busy(g_busy), .pulse_idx(g_idx), .train_done(g_done),
        .dropped_cnt(g_drop)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Timeline model: mode 0 idle, 1 train, 2 refractory.
    int m_mode = 0, m_t0 = 0, m_ref = 0, m_stopped = 0, m_drop = 0, m_prev = 0;
    int gcyc = 0;

    // Per-cycle logs for the directed cases, indexed from the case start.
    int   lc;
    logic log_ack[512], log_pos[512], log_neg[512], log_busy[512], log_done[512];
    logic log_gpos[512], log_gneg[512];
    int   log_drop[512];

    task automatic cycle(input logic req, input logic ab, input logic en,
                         input logic r, input logic greq);
        int o, k, rr, cand;
        logic e_ack, e_pos, e_neg, e_busy, e_done, acc, rise;
        stim_req = req; abort = ab; enable = en; rst = r; g_req = greq;
        @(negedge clk);
        if (m_mode == 1 && gcyc >= m_ref)     m_mode = 2;
        if (m_mode == 2 && gcyc >= m_ref + R) m_mode = 0;
        e_ack = 0; e_pos = 0; e_neg = 0; e_busy = 0; e_done = 0; acc = 0;
        o = 0; k = 0; rr = 0;
        case (m_mode)
            0: begin
                acc   = req && en && !ab && !r;
                e_ack = acc;
            end
            1: begin
                o      = gcyc - m_t0;
                k      = o / PER;
                rr     = o % PER;
                e_pos  = (rr < P);
                e_neg  = (rr >= P + G) && (rr < 2*P + G);
                e_busy = 1;
                e_done = (k == N - 1) && (rr == 2*P + G - 1) && (m_stopped == 0);
            end
            default: e_busy = 1;
        endcase
        chk("stim_ack",    stim_ack,    e_ack);
        chk("phase_pos",   phase_pos,   e_pos);
        chk("phase_neg",   phase_neg,   e_neg);
        chk("busy",        busy,        e_busy);
        chk("train_done",  train_done,  e_done);
        chk("dropped_cnt", dropped_cnt, m_drop);
        if (m_mode == 1) chk("pulse_idx", pulse_idx, k);
        chk("g0_overlap", g_pos & g_neg, 0);
        if (lc < 512) begin
            log_ack[lc] = stim_ack;  log_pos[lc] = phase_pos; log_neg[lc] = phase_neg;
            log_busy[lc] = busy;     log_done[lc] = train_done;
            log_gpos[lc] = g_pos;    log_gneg[lc] = g_neg;
            log_drop[lc] = dropped_cnt;
        end
        lc++;
        rise = req && (m_prev == 0);
        if (r) begin
            m_mode = 0; m_drop = 0; m_prev = 0; m_stopped = 0;
        end else begin
            if (e_busy && rise && m_drop < 255) m_drop++;
            m_prev = req;
            if (acc) begin
                m_mode    = 1;
                m_t0      = gcyc + 1;
                m_ref     = m_t0 + (N - 1)*PER + 2*P + G;
                m_stopped = 0;
            end else if (m_mode == 1 && (ab || !en)) begin
                // Inside a pulse the refractory window waits for the end of
                // that pulse's negative phase; between pulses it starts next.
                cand = (rr < 2*P + G) ? m_t0 + k*PER + 2*P + G : gcyc + 1;
                if (cand < m_ref) m_ref = cand;
                m_stopped = 1;
            end
        end
        gcyc++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
    endtask

    int dcount;

    initial begin
        rst = 1; enable = 1; stim_req = 0; abort = 0; g_req = 0; lc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        // reset state (model idle, all outputs expected 0)
        cycle(0, 0, 1, 0, 0);

        // single 1-cycle request; gap-less instance sees the same request
        lc = 0;
        cycle(1, 0, 1, 0, 1);
        repeat (110) cycle(0, 0, 1, 0, 0);
        chk("c1_ack0",   log_ack[0], 1);
        chk("c1_pos1",   log_pos[1], 1);
        chk("c1_pos4",   log_pos[4], 1);
        chk("c1_gap5",   log_pos[5] | log_neg[5], 0);
        chk("c1_neg7",   log_neg[7], 1);
        chk("c1_neg10",  log_neg[10], 1);
        chk("c1_inter20", log_pos[20] | log_neg[20], 0);
        chk("c1_pos21",  log_pos[21], 1);
        chk("c1_pos41",  log_pos[41], 1);
        chk("c1_neg50",  log_neg[50], 1);
        chk("c1_done50", log_done[50], 1);
        chk("c1_busy100", log_busy[100], 1);
        chk("c1_busy101", log_busy[101], 0);
        chk("g0_pos4",   log_gpos[4], 1);
        chk("g0_neg5",   log_gneg[5], 1);
        chk("g0_neg8",   log_gneg[8], 1);
        chk("g0_neg9",   log_gneg[9], 0);
        dcount = 0;
        for (int i = 0; i < 111; i++) dcount += int'(log_done[i]);
        chk("c1_done_once", dcount, 1);

        // request held high: re-accepted right after the lockout, no drops
        do_reset();
        lc = 0;
        repeat (110) cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("c2_ack101", log_ack[101], 1);
        chk("c2_pos102", log_pos[102], 1);
        chk("c2_drop",   log_drop[105], 0);
        repeat (110) cycle(0, 0, 1, 0, 0);

        // abort during the interphase gap of pulse 0
        do_reset();
        lc = 0;
        for (int c = 0; c < 70; c++) cycle(c == 0, c == 5, 1, 0, 0);
        chk("c3_neg10",  log_neg[10], 1);
        chk("c3_neg11",  log_neg[11], 0);
        chk("c3_busy60", log_busy[60], 1);
        chk("c3_busy61", log_busy[61], 0);
        dcount = 0;
        for (int i = 0; i < 70; i++) dcount += int'(log_done[i]);
        chk("c3_no_done", dcount, 0);

        // reset mid positive phase, then a fresh request
        do_reset();
        lc = 0;
        for (int c = 0; c < 130; c++) cycle(c == 0 || c == 5, 0, 1, c == 2, 0);
        chk("c4_busy3", log_busy[3], 0);
        chk("c4_pos3",  log_pos[3], 0);
        chk("c4_ack5",  log_ack[5], 1);
        chk("c4_pos6",  log_pos[6], 1);

        // three short requests during a train, then saturation
        do_reset();
        lc = 0;
        for (int c = 0; c < 60; c++) cycle(c == 0 || c == 20 || c == 30 || c == 40, 0, 1, 0, 0);
        chk("c5_drop3", log_drop[59], 3);
        for (int c = 0; c < 900; c++) cycle(c[0], 0, 1, 0, 0);
        chk("c5_sat", dropped_cnt, 255);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            logic rq, ab, en, rs;
            rq = ($urandom_range(0, 9) < 3);
            ab = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 99) >= 2);
            rs = ($urandom_range(0, 999) < 2);
            cycle(rq, ab, en, rs, rq);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
